// File: rtl/detector_110.sv
// Serial "110" pattern detector (Moore, overlapping). w is decoded from the
// state register only, so it changes only on clock edges.
module detector_110 (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  output logic       w,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    S1   = 2'b01,
    S11  = 2'b10,
    S110 = 2'b11
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // From S110 a 1 restarts the pattern, so overlapping matches are found.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = a ? S1  : IDLE;
      S1:      state_next = a ? S11 : IDLE;
      S11:     state_next = a ? S11 : S110;
      S110:    state_next = a ? S1  : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign w         = (state == S110);
  assign dbg_state = state;

endmodule

// File: tb/tb_detector_110.sv
// Bench for detector_110: directed sequences plus random stimulus checked
// against a history-based reference (last three samples since reset).
module tb_detector_110;

  logic       clk;
  logic       reset;
  logic       a;
  logic       w;
  logic [1:0] dbg_state;

  int tests_run;
  int tests_failed;

  // Samples since the last reset, newest in bit 0.
  logic [2:0] hist;
  logic [7:0] vec;

  detector_110 dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .w         (w),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Progress implied by the recent history: "110" > "11" > "1" > nothing.
  function automatic logic [1:0] exp_state(input logic [2:0] h);
    if (h == 3'b110)      return 2'b11;
    if (h[1:0] == 2'b11)  return 2'b10;
    if (h[0])             return 2'b01;
    return 2'b00;
  endfunction

  task automatic step(input logic a_v, input logic rst_v);
    @(negedge clk);
    a     = a_v;
    reset = rst_v;
    @(posedge clk);
    if (!rst_v) hist = 3'b000;
    else        hist = {hist[1:0], a_v};
    #1;
    chk("w_model", {7'b0, w}, {7'b0, (hist == 3'b110)});
    chk("state_model", {6'b0, dbg_state}, {6'b0, exp_state(hist)});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    hist         = 3'b000;
    reset        = 1'b0;
    a            = 1'b0;

    // 1: reset held for three edges, then released with a=0
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk("reset_w", {7'b0, w}, 8'h00);
      chk("reset_state", {6'b0, dbg_state}, 8'h00);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1);
      chk("release_state", {6'b0, dbg_state}, 8'h00);
    end

    // 2: 1,1,1,0,0,0,0,0 -> single pulse after the 4th edge
    begin
      logic [7:0] seq2;
      seq2 = 8'b1110_0000;
      vec  = '0;
      for (int i = 0; i < 8; i++) begin
        step(seq2[7-i], 1'b1);
        vec[i] = w;
      end
      chk("long_run_pulses", vec, 8'b0000_1000);
    end

    // 3: 1,1,0,1,1,0 -> pulses after edges 3 and 6
    begin
      logic [5:0] seq3;
      seq3 = 6'b110110;
      vec  = '0;
      for (int i = 0; i < 6; i++) begin
        step(seq3[5-i], 1'b1);
        vec[i] = w;
      end
      chk("back_to_back_pulses", vec, 8'b0010_0100);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // 4: 1,0,1,0,0,1 -> no pulse
    begin
      logic [5:0] seq4;
      seq4 = 6'b101001;
      vec  = '0;
      for (int i = 0; i < 6; i++) begin
        step(seq4[5-i], 1'b1);
        vec[i] = w;
      end
      chk("lone_ones_pulses", vec, 8'h00);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // 5: 1,1 then reset with a=0, release with a=0 -> no pulse, IDLE
    vec = '0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("pre_reset_state", {6'b0, dbg_state}, 8'h02);
    step(1'b0, 1'b0);
    vec[0] = w;
    chk("mid_reset_state", {6'b0, dbg_state}, 8'h00);
    step(1'b0, 1'b1);
    vec[1] = w;
    step(1'b0, 1'b1);
    vec[2] = w;
    chk("mid_reset_pulses", vec, 8'h00);
    chk("post_reset_state", {6'b0, dbg_state}, 8'h00);

    // reset while in S110 discards the detection
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("s110_w", {7'b0, w}, 8'h01);
    step(1'b1, 1'b0);
    chk("s110_reset_w", {7'b0, w}, 8'h00);
    chk("s110_reset_state", {6'b0, dbg_state}, 8'h00);

    // 6: random stimulus with occasional resets
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(1, 0)), ($urandom_range(49, 0) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
